// File: rtl/display_timer.sv
// display_timer
// Four-digit multiplexed seven-segment driver for the irrigation countdown.
// Scans a common-anode display as MM.SS, blanks a leading zero in the
// tens-of-minutes digit and blinks the whole display while the countdown
// finished flag is high. All outputs are registered; the digit values are
// captured once per scan frame so a frame never mixes old and new digits.
//
// Ports:
//   clock  - system clock
//   reset  - asynchronous reset, active low
//   Us     - unit-of-seconds digit (BCD)
//   Ds     - tens-of-seconds digit (BCD)
//   Um     - unit-of-minutes digit (BCD)
//   Dm     - tens-of-minutes digit (BCD)
//   fim    - countdown finished (level), enables blinking
//   ativo  - display enable; low keeps the display dark
//   an     - digit enables, active low (an[0]=Us ... an[3]=Dm)
//   seg    - segments gfedcba, active low
//   dp     - decimal point, active low (lit between minutes and seconds)
module display_timer #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_SCANS = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] Us,
  input  logic [3:0] Ds,
  input  logic [3:0] Um,
  input  logic [3:0] Dm,
  input  logic       fim,
  input  logic       ativo,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(BLINK_SCANS + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE    = PW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

  typedef enum logic {
    PH_ON,
    PH_OFF
  } phase_t;

  typedef enum logic [1:0] {
    DARK,
    SHOW,
    BLINK_ON,
    BLINK_OFF
  } mode_t;

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [1:0]    idx;
  logic [1:0]    next_idx;
  logic [3:0]    snap_ds;
  logic [3:0]    snap_um;
  logic [3:0]    snap_dm;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_next;
  phase_t        phase;
  phase_t        phase_next;
  mode_t         mode;
  logic [3:0]    digit;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  assign tick     = (pre_cnt == PRE_LAST);
  assign next_idx = idx + 2'd1;

  // Free-running prescaler, slot index and per-frame digit snapshot. These
  // keep running while the display is disabled so re-enabling does not
  // restart the scan.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
      idx     <= 2'd0;
      snap_ds <= 4'd0;
      snap_um <= 4'd0;
      snap_dm <= 4'd0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_ONE;
      if (tick) begin
        idx <= next_idx;
        if (idx == 2'd3) begin
          snap_ds <= Ds;
          snap_um <= Um;
          snap_dm <= Dm;
        end
      end
    end
  end

  // Blink phase state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase     <= PH_ON;
      blink_cnt <= '0;
    end else begin
      phase     <= phase_next;
      blink_cnt <= blink_next;
    end
  end

  // Blink next-state: counts slot ticks only while fim is high and flips
  // the phase at the terminal count; with fim low it is parked at phase on.
  always_comb begin
    phase_next = phase;
    blink_next = blink_cnt;
    if (!fim) begin
      phase_next = PH_ON;
      blink_next = '0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_next = '0;
        phase_next = (phase == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blink_next = blink_cnt + BLINK_ONE;
      end
    end
  end

  // Display mode; the current (pre-toggle) phase is what the next output
  // load uses, so a blink half-period spans exactly BLINK_SCANS slots.
  always_comb begin
    mode = SHOW;
    if (!ativo) begin
      mode = DARK;
    end else if (fim) begin
      mode = (phase == PH_ON) ? BLINK_ON : BLINK_OFF;
    end
  end

  // Slot 0 of a new frame is loaded on the same edge that takes the
  // snapshot, so it must read Us live; other slots read the snapshot.
  always_comb begin
    digit = Us;
    case (next_idx)
      2'd0:    digit = Us;
      2'd1:    digit = snap_ds;
      2'd2:    digit = snap_um;
      default: digit = snap_dm;
    endcase
  end

  always_comb begin
    an_d  = ~(4'b0001 << next_idx);
    seg_d = seg_decode(digit);
    dp_d  = (next_idx != 2'd2);
    if ((next_idx == 2'd3) && (digit == 4'd0)) begin
      seg_d = 7'b1111111;
    end
    if (mode == BLINK_OFF) begin
      an_d = 4'b1111;
    end
  end

  // Output registers load once per slot; disabling the display blanks them
  // on the very next edge rather than waiting for a tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (mode == DARK) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (tick) begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_display_timer.sv
// tb_display_timer
// Directed bench for display_timer with SCAN_DIV=4, BLINK_SCANS=2.
// Expected {an,seg,dp} values are queued when stimulus is driven and
// popped and compared when the DUT output is sampled (on the falling edge).
module tb_display_timer;

  logic       clock;
  logic       reset;
  logic [3:0] Us;
  logic [3:0] Ds;
  logic [3:0] Um;
  logic [3:0] Dm;
  logic       fim;
  logic       ativo;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  nCompared;
  int  nMismatched;

  localparam logic [3:0]  AN_DARK  = 4'b1111;
  localparam logic [6:0]  SEG_DARK = 7'b1111111;

  display_timer #(
    .SCAN_DIV   (4),
    .BLINK_SCANS(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .Us   (Us),
    .Ds   (Ds),
    .Um   (Um),
    .Dm   (Dm),
    .fim  (fim),
    .ativo(ativo),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [3:0] us, input logic [3:0] ds,
                               input logic [3:0] um, input logic [3:0] dm,
                               input logic f, input logic a);
    Us    = us;
    Ds    = ds;
    Um    = um;
    Dm    = dm;
    fim   = f;
    ativo = a;
  endtask

  task automatic pushExpect(input string tag, input logic [3:0] e_an,
                            input logic [6:0] e_seg, input logic e_dp);
    sb_t e;
    e.tag = tag;
    e.exp = {e_an, e_seg, e_dp};
    sb_q.push_back(e);
  endtask

  task automatic checkOutput();
    sb_t         e;
    logic [11:0] obs;
    obs = {an, seg, dp};
    nCompared++;
    if (sb_q.size() == 0) begin
      nMismatched++;
      $error("[TB] FAIL scoreboard_empty: observed an=%b seg=%b dp=%b, expected an entry",
             an, seg, dp);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        nMismatched++;
        $error("[TB] FAIL %s: observed an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               e.tag, obs[11:8], obs[7:1], obs[0], e.exp[11:8], e.exp[7:1], e.exp[0]);
      end
    end
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic stepCheck(input string tag, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp);
    pushExpect(tag, e_an, e_seg, e_dp);
    advance(4);
    checkOutput();
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset       = 1'b0;
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);

    // Reset held low with random digits: display stays dark.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b1);
      #1;
      pushExpect("reset_hold", AN_DARK, SEG_DARK, 1'b1);
      checkOutput();
    end

    // Release; first frame shows the zero snapshot, slot 0 reads Us live.
    @(negedge clock);
    applyStimulus(4'd7, 4'd3, 4'd2, 4'd1, 1'b0, 1'b1);
    reset = 1'b1;
    pushExpect("before_first_tick", AN_DARK, SEG_DARK, 1'b1);
    advance(3);
    checkOutput();
    pushExpect("first_update_slot1", 4'b1101, 7'b1000000, 1'b1);
    advance(1);
    checkOutput();
    stepCheck("frame1_slot2", 4'b1011, 7'b1000000, 1'b0);
    stepCheck("frame1_slot3_blank", 4'b0111, 7'b1111111, 1'b1);
    stepCheck("frame1_slot0", 4'b1110, 7'b1111000, 1'b1);

    // Normal scan of 12:37 shown as 12.37.
    stepCheck("scan_slot1", 4'b1101, 7'b0110000, 1'b1);
    pushExpect("scan_slot1_stable", 4'b1101, 7'b0110000, 1'b1);
    advance(2);
    checkOutput();
    pushExpect("scan_slot2", 4'b1011, 7'b0100100, 1'b0);
    advance(2);
    checkOutput();
    stepCheck("scan_slot3", 4'b0111, 7'b1111001, 1'b1);
    stepCheck("scan_slot0", 4'b1110, 7'b1111000, 1'b1);

    // Dm=0 and invalid Um mid-frame: not visible until the next frame.
    applyStimulus(4'd7, 4'd3, 4'd12, 4'd0, 1'b0, 1'b1);
    stepCheck("midframe_slot1", 4'b1101, 7'b0110000, 1'b1);
    stepCheck("midframe_slot2_old", 4'b1011, 7'b0100100, 1'b0);
    stepCheck("midframe_slot3_old", 4'b0111, 7'b1111001, 1'b1);
    stepCheck("midframe_slot0", 4'b1110, 7'b1111000, 1'b1);
    stepCheck("newframe_slot1", 4'b1101, 7'b0110000, 1'b1);

    // Us changes while slot 1 shows; next slot 0 shows 4.
    applyStimulus(4'd4, 4'd3, 4'd12, 4'd0, 1'b0, 1'b1);
    stepCheck("invalid_dash_slot2", 4'b1011, 7'b0111111, 1'b0);
    stepCheck("leading_zero_slot3", 4'b0111, 7'b1111111, 1'b1);
    stepCheck("snapshot_us_slot0", 4'b1110, 7'b0011001, 1'b1);

    // Blink: two slots on, two slots dark, segments keep decoding.
    applyStimulus(4'd4, 4'd3, 4'd12, 4'd0, 1'b1, 1'b1);
    stepCheck("blink_on_a", 4'b1101, 7'b0110000, 1'b1);
    stepCheck("blink_on_b", 4'b1011, 7'b0111111, 1'b0);
    stepCheck("blink_off_a", AN_DARK, 7'b1111111, 1'b1);
    stepCheck("blink_off_b", AN_DARK, 7'b0011001, 1'b1);
    stepCheck("blink_on_c", 4'b1101, 7'b0110000, 1'b1);
    stepCheck("blink_on_d", 4'b1011, 7'b0111111, 1'b0);
    stepCheck("blink_off_c", AN_DARK, 7'b1111111, 1'b1);

    // fim drops during the dark half: next slot scans normally.
    applyStimulus(4'd4, 4'd3, 4'd12, 4'd0, 1'b0, 1'b1);
    stepCheck("fim_drop_resume", 4'b1110, 7'b0011001, 1'b1);

    // ativo drops mid-slot: dark on the next edge, index keeps running.
    pushExpect("ativo_mid_slot_hold", 4'b1110, 7'b0011001, 1'b1);
    advance(1);
    checkOutput();
    applyStimulus(4'd4, 4'd3, 4'd12, 4'd0, 1'b0, 1'b0);
    pushExpect("ativo_low_next_edge", AN_DARK, SEG_DARK, 1'b1);
    advance(1);
    checkOutput();
    pushExpect("ativo_low_at_tick", AN_DARK, SEG_DARK, 1'b1);
    advance(2);
    checkOutput();
    applyStimulus(4'd4, 4'd3, 4'd12, 4'd0, 1'b0, 1'b1);
    pushExpect("ativo_high_waits_tick", AN_DARK, SEG_DARK, 1'b1);
    advance(1);
    checkOutput();
    pushExpect("ativo_resume_slot2", 4'b1011, 7'b0111111, 1'b0);
    advance(3);
    checkOutput();

    // Reset mid-slot clears everything, including the snapshot.
    advance(1);
    reset = 1'b0;
    #1;
    pushExpect("reset_mid_frame", AN_DARK, SEG_DARK, 1'b1);
    checkOutput();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    stepCheck("reset_restart_slot1", 4'b1101, 7'b1000000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
